ram_loader: RTL and testbench

//   Bus initiator that fills the 16x8 program RAM from a byte stream before the CPU runs.

---
 rtl/ram_loader_if.sv | 25 ++
 rtl/ram_loader.sv | 113 +++++++++++
 tb/tb_ram_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_if.sv
// Stream-in and RAM-port signals of the program loader.
// master = loader side, slave = host stream source plus RAM.
interface ram_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              ri;
  logic              ro;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  s_valid, s_data, mem_rdata,
    output s_ready, mem_address, ri, ro, mem_wdata
  );

  modport slave (
    output s_valid, s_data, mem_rdata,
    input  s_ready, mem_address, ri, ro, mem_wdata
  );
endinterface

// File: rtl/ram_loader.sv
// Fills the program RAM from a byte stream, reads it back, and compares
// the two modular byte sums. Holds the CPU off the bus while working.
module ram_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  ram_loader_if.master bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] load_sum_q, load_sum_d;
  logic [DATA_W-1:0] read_sum_q, read_sum_d;
  logic              error_q, error_d;

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset term in the sensitivity list is what makes ri/ro drop without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      load_sum_q <= '0;
      read_sum_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      load_sum_q <= load_sum_d;
      read_sum_q <= read_sum_d;
      error_q    <= error_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    load_sum_d      = load_sum_q;
    read_sum_d      = read_sum_q;
    error_d         = error_q;
    bus.s_ready     = 1'b0;
    bus.ri          = 1'b0;
    bus.ro          = 1'b0;
    bus.mem_address = addr_q;
    bus.mem_wdata   = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          addr_d     = '0;
          load_sum_d = '0;
          read_sum_d = '0;
          error_d    = 1'b0;
        end
      end

      S_LOAD: begin
        bus.s_ready   = 1'b1;
        bus.ri        = bus.s_valid;
        bus.mem_wdata = bus.s_data;
        if (bus.s_valid) begin
          load_sum_d = load_sum_q + bus.s_data;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_VERIFY;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      S_VERIFY: begin
        bus.ro     = 1'b1;
        read_sum_d = read_sum_q + bus.mem_rdata;
        if (addr_q == LAST_ADDR) begin
          // Compare against the sum including this final read.
          addr_d  = '0;
          state_d = S_DONE;
          error_d = (read_sum_d != load_sum_q);
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: a 16-byte instance and a 4-byte instance,
// each with a behavioural RAM; expected bus events are queued ahead of stimulus.
module tb_ram_loader;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_DONE, EV_BAD} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  ev_t q0[$];
  ev_t q1[$];

  logic [1:0] sv, st;
  logic [7:0] sd [2];
  logic       ram_clr, flip5;
  logic [7:0] ram0 [16];
  logic [7:0] ram1 [16];

  logic [1:0] ri_w, ro_w, sr_w, busy_w, hold_w, done_w, err_w, done_prev;
  logic [3:0] addr_w [2];
  logic [7:0] wd_w   [2];

  ram_loader_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();
  ram_loader_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();

  ram_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .bus(bus0),
    .cpu_hold(hold_w[0]), .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0])
  );

  ram_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_LEN(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .bus(bus1),
    .cpu_hold(hold_w[1]), .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1])
  );

  assign bus0.s_valid   = sv[0];
  assign bus0.s_data    = sd[0];
  assign bus0.mem_rdata = ram0[bus0.mem_address];
  assign bus1.s_valid   = sv[1];
  assign bus1.s_data    = sd[1];
  assign bus1.mem_rdata = ram1[bus1.mem_address];

  assign ri_w      = {bus1.ri, bus0.ri};
  assign ro_w      = {bus1.ro, bus0.ro};
  assign sr_w      = {bus1.s_ready, bus0.s_ready};
  assign addr_w[0] = bus0.mem_address;
  assign addr_w[1] = bus1.mem_address;
  assign wd_w[0]   = bus0.mem_wdata;
  assign wd_w[1]   = bus1.mem_wdata;

  // RAM models; dut0's copy can corrupt bit 0 of address 5 on write.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) begin
        ram0[i] <= 8'hEE;
        ram1[i] <= 8'hEE;
      end
    end else begin
      if (bus0.ri)
        ram0[bus0.mem_address] <= bus0.mem_wdata ^ ((flip5 && bus0.mem_address == 4'd5) ? 8'h01 : 8'h00);
      if (bus1.ri)
        ram1[bus1.mem_address] <= bus1.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic ev_t mk_ev(input ev_kind_t k, input int a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = 4'(a);
    e.data = d;
    return e;
  endfunction

  task automatic push_ev(input int w, input ev_t e);
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic sb_compare(input int w, input ev_t got);
    ev_t exp;
    int  depth;
    depth = (w == 0) ? q0.size() : q1.size();
    if (depth == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL sb_dut%0d: got event 0x%0h, expected no event", w, got);
    end else begin
      if (w == 0) exp = q0.pop_front();
      else        exp = q1.pop_front();
      check($sformatf("sb_dut%0d", w), 32'(got), 32'(exp));
    end
  endtask

  // Monitor: one sample per cycle, well clear of the rising edge.
  initial done_prev = 2'b00;
  always begin
    ev_t got;
    @(negedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      if (rst_n && (ri_w[w] || ro_w[w])) begin
        got.kind = (ri_w[w] && ro_w[w]) ? EV_BAD : (ri_w[w] ? EV_WR : EV_RD);
        got.addr = addr_w[w];
        got.data = wd_w[w];
        sb_compare(w, got);
      end
      if (done_w[w] && !done_prev[w])
        sb_compare(w, mk_ev(EV_DONE, 0, {7'b0, err_w[w]}));
      done_prev[w] = done_w[w];
    end
  end

  task automatic clear_rams();
    @(negedge clk);
    ram_clr = 1'b1;
    @(negedge clk);
    ram_clr = 1'b0;
  endtask

  task automatic pulse_start(input int w);
    @(negedge clk);
    st[w] = 1'b1;
    @(negedge clk);
    st[w] = 1'b0;
  endtask

  // One full load + verify; start_at >= 0 re-pulses start alongside that byte.
  task automatic run_load(input int w, input int len, input logic [7:0] base,
                          input int gap, input int start_at, input logic exp_err);
    int n;
    for (int i = 0; i < len; i++) push_ev(w, mk_ev(EV_WR, i, base + 8'(i)));
    for (int i = 0; i < len; i++) push_ev(w, mk_ev(EV_RD, i, 8'h00));
    push_ev(w, mk_ev(EV_DONE, 0, {7'b0, exp_err}));

    pulse_start(w);
    check("start_busy", 32'(busy_w[w]), 32'd1);
    check("start_clears_done", 32'(done_w[w]), 32'd0);
    check("start_clears_error", 32'(err_w[w]), 32'd0);

    for (int i = 0; i < len; i++) begin
      sv[w] = 1'b1;
      sd[w] = base + 8'(i);
      if (i == start_at) st[w] = 1'b1;
      @(negedge clk);
      st[w] = 1'b0;
      sv[w] = 1'b0;
      check("busy_in_load", 32'(busy_w[w]), 32'd1);
      check("hold_in_load", 32'(hold_w[w]), 32'd1);
      if (i < len - 1) begin
        for (int g = 0; g < gap; g++) begin
          #1;
          check("gap_addr_frozen", 32'(addr_w[w]), 32'(i + 1));
          @(negedge clk);
        end
      end
    end

    n = 0;
    while (!done_w[w] && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 32'(n), 32'(len));
    check("done_error", 32'(err_w[w]), 32'(exp_err));
    @(negedge clk);
    check("done_busy_low", 32'(busy_w[w]), 32'd0);
    check("sb_drained", 32'((w == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    rst_n   = 1'b0;
    sv      = 2'b00;
    st      = 2'b00;
    sd[0]   = 8'h00;
    sd[1]   = 8'h00;
    ram_clr = 1'b0;
    flip5   = 1'b0;

    #3;
    for (int w = 0; w < 2; w++) begin
      check("rst_outputs", 32'({sr_w[w], ri_w[w], ro_w[w], busy_w[w], done_w[w], err_w[w], hold_w[w]}), 32'd0);
      check("rst_addr", 32'(addr_w[w]), 32'd0);
      check("rst_wdata", 32'(wd_w[w]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back 0x00..0x0F
    clear_rams();
    run_load(0, 16, 8'h00, 0, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram0[i] !== 8'(i)) bad++;
    check("ram_image_t1", 32'(bad), 32'd0);

    // 2: same bytes with 3-cycle gaps
    clear_rams();
    run_load(0, 16, 8'h00, 3, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram0[i] !== 8'(i)) bad++;
    check("ram_image_t2", 32'(bad), 32'd0);

    // 3: RAM corrupts address 5 -> readback mismatch
    clear_rams();
    flip5 = 1'b1;
    run_load(0, 16, 8'h00, 0, -1, 1'b1);
    flip5 = 1'b0;

    // 4: start mid-load is ignored; also clears the error from test 3
    run_load(0, 16, 8'h40, 0, 7, 1'b0);

    // 5: reset mid-load, start held during reset
    for (int i = 0; i < 6; i++) push_ev(0, mk_ev(EV_WR, i, 8'h30 + 8'(i)));
    pulse_start(0);
    for (int i = 0; i < 5; i++) begin
      sv[0] = 1'b1;
      sd[0] = 8'h30 + 8'(i);
      @(negedge clk);
    end
    sd[0] = 8'h35;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ri", 32'(ri_w[0]), 32'd0);
    check("rst_mid_s_ready", 32'(sr_w[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    check("rst_mid_hold", 32'(hold_w[0]), 32'd0);
    sv[0] = 1'b0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_release_busy", 32'(busy_w[0]), 32'd0);
    check("rst_release_done", 32'(done_w[0]), 32'd0);
    check("rst_release_addr", 32'(addr_w[0]), 32'd0);
    check("rst_sb_drained", 32'(q0.size()), 32'd0);

    // 6: LOAD_LEN=4 instance, then a second load from DONE
    clear_rams();
    run_load(1, 4, 8'hA0, 0, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++)  if (ram1[i] !== 8'hA0 + 8'(i)) bad++;
    for (int i = 4; i < 16; i++) if (ram1[i] !== 8'hEE) bad++;
    check("ram_image_t6", 32'(bad), 32'd0);
    run_load(1, 4, 8'h5C, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
